rgb565_gray_packer: RTL and testbench

- Streaming front-end stage between the camera pixel interface and the frame-buffer DMA writer.
- Accepts one RGB565 pixel per cycle and converts it to 8-bit grayscale.
- Packs four gray bytes into one 32-bit word, little-endian by pixel order, and buffers the words in a small FIFO.
- The FIFO is drained by the DMA through a valid/ready handshake. Software then sees packed gray words in memory instead of raw RGB565.

---
 rtl/rgb565_gray_packer_if.sv | 27 ++
 rtl/rgb565_gray_packer.sv | 141 ++++++++++++++
 tb/tb_rgb565_gray_packer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb565_gray_packer_if.sv
// Pixel-in / packed-word-out stream bundle for rgb565_gray_packer.
// master drives pixels and word ready; slave is the packer itself.
interface rgb565_gray_packer_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          pixelValid;
  logic [15:0]   pixel;
  logic          lastInLine;
  logic          pixelReady;
  logic          wordValid;
  logic [31:0]   wordData;
  logic [3:0]    wordByteEn;
  logic          wordReady;
  logic [CW-1:0] fifoCount;

  modport master (
    output pixelValid, pixel, lastInLine, wordReady,
    input  pixelReady, wordValid, wordData, wordByteEn, fifoCount
  );

  modport slave (
    input  pixelValid, pixel, lastInLine, wordReady,
    output pixelReady, wordValid, wordData, wordByteEn, fifoCount
  );
endinterface

// File: rtl/rgb565_gray_packer.sv
// RGB565 -> 8-bit gray conversion, packing of four gray bytes per 32-bit word,
// and a small word FIFO drained over a valid/ready handshake.
module rgb565_gray_packer #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clear,
  rgb565_gray_packer_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 36;

  // Shift-add luma approximation; worst case 245 so the low byte never overflows
  function automatic logic [7:0] to_gray(input logic [15:0] p);
    logic [9:0] r8, g8, b8, sum;
    r8  = {2'b00, p[15:11], 3'b000};
    g8  = {2'b00, p[10:5], 2'b00};
    b8  = {2'b00, p[4:0], 3'b000};
    sum = (r8 >> 3) + (r8 >> 4) + (r8 >> 6) + (r8 >> 7)
        + (g8 >> 1) + (g8 >> 3) + (g8 >> 4) + (g8 >> 5)
        + (b8 >> 4) + (b8 >> 7) + (b8 >> 8);
    return 8'(sum);
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic [7:0]    s1_gray_q, s1_gray_d;
  logic          s1_last_q, s1_last_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   bytes_q, bytes_d;
  logic [3:0]    be_q, be_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];

  logic          pixel_ready_c;
  logic          word_valid_c;
  logic          accept_c, push_c, pop_c;
  logic [EW-1:0] push_entry_c;
  logic [EW-1:0] head_c;

  assign pixel_ready_c  = ready_q & ~clear;
  assign word_valid_c   = (count_q != '0);
  assign accept_c       = bus.pixelValid & pixel_ready_c;
  assign head_c         = mem_q[rd_q];

  assign bus.pixelReady = pixel_ready_c;
  assign bus.wordValid  = word_valid_c;
  assign bus.wordData   = head_c[31:0];
  assign bus.wordByteEn = head_c[35:32];
  assign bus.fifoCount  = count_q;

  // Next-state: stage-1 capture, packer, FIFO bookkeeping; clear overrides all
  always_comb begin
    s1_valid_d   = accept_c;
    s1_gray_d    = to_gray(bus.pixel);
    s1_last_d    = bus.lastInLine;
    idx_d        = idx_q;
    bytes_d      = bytes_q;
    be_d         = be_q;
    push_c       = 1'b0;
    push_entry_c = '0;
    pop_c        = word_valid_c & bus.wordReady;

    if (s1_valid_q) begin
      bytes_d[{idx_q, 3'b000} +: 8] = s1_gray_q;
      be_d[idx_q]                   = 1'b1;
      if (idx_q == 2'd3 || s1_last_q) begin
        push_c       = 1'b1;
        push_entry_c = {be_d, bytes_d};
        idx_d        = 2'd0;
        bytes_d      = '0;
        be_d         = '0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end

    if (clear) begin
      s1_valid_d = 1'b0;
      idx_d      = 2'd0;
      bytes_d    = '0;
      be_d       = '0;
      push_c     = 1'b0;
      pop_c      = 1'b0;
    end

    wr_d = push_c ? wr_q + AW'(1) : wr_q;
    rd_d = pop_c  ? rd_q + AW'(1) : rd_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end

    // Two words may still be in flight behind an accepted pixel
    ready_d = (count_d <= CW'(FIFO_DEPTH - 2));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_gray_q  <= '0;
      s1_last_q  <= 1'b0;
      idx_q      <= '0;
      bytes_q    <= '0;
      be_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_gray_q  <= s1_gray_d;
      s1_last_q  <= s1_last_d;
      idx_q      <= idx_d;
      bytes_q    <= bytes_d;
      be_q       <= be_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
    end
  end

  // Word storage; zeroed on reset so the head reads 0 while empty
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wr_q] <= push_entry_c;
    end
  end
endmodule

// File: tb/tb_rgb565_gray_packer.sv
// Directed and random bench for rgb565_gray_packer with a cycle-level
// reference model feeding a word scoreboard.
module tb_rgb565_gray_packer;
  localparam int unsigned DEPTH = 8;

  logic clock;
  logic resetn;
  logic clear;

  rgb565_gray_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  rgb565_gray_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_gray(input logic [15:0] p);
    int r8, g8, b8, s;
    r8 = int'(p[15:11]) * 8;
    g8 = int'(p[10:5]) * 4;
    b8 = int'(p[4:0]) * 8;
    s  = r8 / 8 + r8 / 16 + r8 / 64 + r8 / 128
       + g8 / 2 + g8 / 8 + g8 / 16 + g8 / 32
       + b8 / 16 + b8 / 128 + b8 / 256;
    return 8'(s);
  endfunction

  // Reference model state
  logic [35:0] q[$];
  int          m_idx = 0;
  logic [31:0] m_bytes = '0;
  logic [3:0]  m_be = '0;
  logic        m_pend = 1'b0;
  logic [7:0]  m_gray = '0;
  logic        m_last = 1'b0;
  logic        hold = 1'b0;
  logic [35:0] held = '0;

  task automatic model_reset();
    q.delete();
    m_idx   = 0;
    m_bytes = '0;
    m_be    = '0;
    m_pend  = 1'b0;
  endtask

  task automatic model_pack(input logic [7:0] g, input logic last);
    m_bytes[8*m_idx +: 8] = g;
    m_be[m_idx]           = 1'b1;
    if (m_idx == 3 || last) begin
      q.push_back({m_be, m_bytes});
      m_idx   = 0;
      m_bytes = '0;
      m_be    = '0;
    end else begin
      m_idx++;
    end
  endtask

  // Monitor: sampled on the falling edge, describing the coming rising edge
  always @(negedge clock) begin
    if (!resetn) begin
      model_reset();
      hold = 1'b0;
    end else begin
      chk("count", 36'(bus.fifoCount), 36'(q.size()));
      chk("valid", 36'(bus.wordValid), 36'(q.size() != 0));
      chk("no_overflow", 36'(bus.fifoCount <= 4'(DEPTH)), 36'd1);
      if (hold) chk("head_stable", {bus.wordByteEn, bus.wordData}, held);
      hold = bus.wordValid && !bus.wordReady && !clear;
      held = {bus.wordByteEn, bus.wordData};
      if (clear) begin
        model_reset();
      end else begin
        if (bus.wordValid && bus.wordReady) begin
          chk("pop_nonempty", 36'(q.size() != 0), 36'd1);
          if (q.size() != 0) chk("word", {bus.wordByteEn, bus.wordData}, q.pop_front());
        end
        if (m_pend) model_pack(m_gray, m_last);
        m_pend = bus.pixelValid && bus.pixelReady;
        if (m_pend) begin
          m_gray = ref_gray(bus.pixel);
          m_last = bus.lastInLine;
          n_acc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] p, input logic last);
    bus.pixelValid = 1'b1;
    bus.pixel      = p;
    bus.lastInLine = last;
    tick();
  endtask

  task automatic idle();
    bus.pixelValid = 1'b0;
    bus.lastInLine = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] be);
    chk({tag, "_valid"}, 36'(bus.wordValid), 36'd1);
    chk({tag, "_data"}, 36'(bus.wordData), 36'(d));
    chk({tag, "_be"}, 36'(bus.wordByteEn), 36'(be));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pready"}, 36'(bus.pixelReady), 36'd0);
    chk({tag, "_wvalid"}, 36'(bus.wordValid), 36'd0);
    chk({tag, "_wdata"}, 36'(bus.wordData), 36'd0);
    chk({tag, "_wbe"}, 36'(bus.wordByteEn), 36'd0);
    chk({tag, "_count"}, 36'(bus.fifoCount), 36'd0);
  endtask

  initial begin
    bit dropped;
    resetn         = 1'b1;
    clear          = 1'b0;
    bus.pixelValid = 1'b0;
    bus.pixel      = '0;
    bus.lastInLine = 1'b0;
    bus.wordReady  = 1'b0;
    #1 resetn = 1'b0;
    #2 chk_reset_outs("reset");
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("pready_after_reset", 36'(bus.pixelReady), 36'd1);

    // Full word from four back-to-back pixels, 2-cycle latency
    bus.wordReady = 1'b1;
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    send(16'hF800, 1'b0);
    send(16'h07E0, 1'b0);
    idle();
    chk("t1_lat_k1", 36'(bus.wordValid), 36'd0);
    tick();
    chk_word("t1", 32'hB332_00F5, 4'hF);
    tick();

    // Three-pixel partial line
    send(16'h001F, 1'b0);
    send(16'h001F, 1'b0);
    send(16'h001F, 1'b1);
    idle();
    tick();
    chk_word("t2", 32'h0010_1010, 4'b0111);
    tick();

    // Single-pixel line, then next group starts at byte 0
    send(16'hFFFF, 1'b1);
    idle();
    tick();
    chk_word("t3a", 32'h0000_00F5, 4'b0001);
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    send(16'hFFFF, 1'b0);
    idle();
    tick();
    chk_word("t3b", 32'hF500_0000, 4'hF);
    tick();

    // Stall: fill the FIFO with single-pixel words, then drain
    bus.wordReady  = 1'b0;
    bus.pixelValid = 1'b1;
    bus.lastInLine = 1'b1;
    dropped        = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      bus.pixel = 16'($urandom);
      tick();
      if (!bus.pixelReady) dropped = 1'b1;
    end
    chk("t4_ready_dropped", 36'(dropped), 36'd1);
    chk("t4_count_at_drop", 36'(bus.fifoCount), 36'd7);
    repeat (5) tick();
    chk("t4_count_full", 36'(bus.fifoCount), 36'd8);
    chk("t4_ready_full", 36'(bus.pixelReady), 36'd0);
    idle();
    bus.wordReady = 1'b1;
    for (int i = 0; i < 30 && bus.wordValid; i++) tick();
    chk("t4_drained", 36'(bus.fifoCount), 36'd0);

    // clear with 3 queued words and 2 packed bytes
    bus.wordReady = 1'b0;
    for (int i = 0; i < 14; i++) send(16'($urandom), 1'b0);
    idle();
    repeat (3) tick();
    chk("t5_queued", 36'(bus.fifoCount), 36'd3);
    clear          = 1'b1;
    bus.pixelValid = 1'b1;
    bus.pixel      = 16'hFFFF;
    #1;
    chk("t5_pready_clear", 36'(bus.pixelReady), 36'd0);
    tick();
    clear = 1'b0;
    idle();
    chk("t5_count", 36'(bus.fifoCount), 36'd0);
    chk("t5_wvalid", 36'(bus.wordValid), 36'd0);
    bus.wordReady = 1'b1;
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    send(16'hF800, 1'b0);
    send(16'h07E0, 1'b0);
    idle();
    tick();
    chk_word("t5_clean", 32'hB332_00F5, 4'hF);
    tick();

    // Random traffic against the model, with an async reset pulse mid-stream
    for (int cyc = 0; cyc < 40000 && n_acc < 10000 + 40; cyc++) begin
      bus.pixelValid = ($urandom_range(3) != 0);
      bus.pixel      = 16'($urandom);
      bus.lastInLine = ($urandom_range(7) == 0);
      bus.wordReady  = ($urandom_range(2) != 0);
      tick();
      if (cyc == 6000) begin
        #2 resetn = 1'b0;
        #1 chk_reset_outs("async_reset");
      end
      if (cyc == 6002) resetn = 1'b1;
    end
    chk("t6_pixels_done", 36'(n_acc >= 10000), 36'd1);
    idle();
    bus.wordReady = 1'b1;
    repeat (20) tick();
    chk("t6_final_count", 36'(bus.fifoCount), 36'd0);
    chk("t6_final_valid", 36'(bus.wordValid), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
